// File: rtl/square_ring_animator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// square_ring_animator : square glyph circling a multiplexed 7-seg row
// Revision 1.0
// ---------------------------------------------------------------------------
module square_ring_animator #(
   parameter int DIGITS = 4,
   parameter int PER_W  = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              en,
   input  logic              cw,
   input  logic              oneshot,
   input  logic [PER_W-1:0]  period,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        sseg,
   output logic              busy,
   output logic              done
);

   localparam int PW = $clog2(2 * DIGITS);

   localparam logic [6:0]    c_top   = 7'b0011100;
   localparam logic [6:0]    c_bot   = 7'b1100010;
   localparam logic [6:0]    c_blank = 7'b1111111;
   localparam logic [PW-1:0] c_dig   = PW'(DIGITS);
   localparam logic [PW-1:0] c_last  = PW'(2 * DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     p_q, p_d;
   logic [PW-1:0]     sc_q, sc_d;
   logic [PER_W-1:0]  t_q, t_d;
   logic [PW-1:0]     w_idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         sc_q    <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         sc_q    <= sc_d;
         t_q     <= t_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      sc_d    = sc_q;
      t_d     = t_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d = S_RUN;
               p_d     = '0;
               sc_d    = '0;
               t_d     = '0;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
               p_d     = '0;
               sc_d    = '0;
               t_d     = '0;
            end else if (start) begin
               p_d  = '0;
               sc_d = '0;
               t_d  = '0;
            end else if (en) begin
               if (t_q >= period) begin
                  t_d = '0;
                  // final step of a one-shot revolution ends without moving
                  if (oneshot && (sc_q == c_last)) begin
                     state_d = S_DONE;
                  end else begin
                     if (cw) p_d = (p_q == c_last) ? '0 : p_q + PW'(1);
                     else    p_d = (p_q == '0) ? c_last : p_q - PW'(1);
                     sc_d = (sc_q == c_last) ? '0 : sc_q + PW'(1);
                  end
               end else begin
                  t_d = t_q + PER_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            p_d     = '0;
            sc_d    = '0;
            t_d     = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      an    = '1;
      sseg  = c_blank;
      busy  = 1'b0;
      done  = 1'b0;
      w_idx = '0;
      unique case (state_q)
         S_RUN: begin
            busy = 1'b1;
            // top pass runs left to right, bottom pass right to left
            if (p_q < c_dig) begin
               sseg  = c_top;
               w_idx = c_dig - PW'(1) - p_q;
            end else begin
               sseg  = c_bot;
               w_idx = p_q - c_dig;
            end
            an = ~(DIGITS'(1) << w_idx);
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/square_ring_animator.md
# square_ring_animator

Parametrised successor to the single-ring seven-segment animator. It drives a DIGITS-wide multiplexed seven-segment display with a square glyph that circles the digit row: upper square across the top, lower square back along the bottom. It adds a programmable step period, run-time direction control, pause, and a one-shot mode that stops after one revolution and reports done. It sits between the board clock domain and the anode/segment pins.

## Interface
- DIGITS, 4, number of display digits; legal 2..8.
- PER_W, 18, width of the step-period timer and the `period` input.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request to begin an animation from position 0.
- stop  in  1  one-cycle request to abort to idle.
- en  in  1  step enable; low freezes the animation in place.
- cw  in  1  direction: 1 = clockwise, 0 = counter-clockwise.
- oneshot  in  1  1 = stop after one full revolution; 0 = run continuously.
- period  in  PER_W  step interval minus one, in clk cycles.
- an  out  DIGITS  anode enables, active-low; bit DIGITS-1 is the leftmost digit.
- sseg  out  7  segment pattern, active-low.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a one-shot revolution completes.

## Operation
- Glyph constants:
  - TOP = 7'b0011100 (upper square).
  - BOT = 7'b1100010 (lower square).
  - BLANK = 7'b1111111.
- Position register p ranges over 0..2*DIGITS-1 and is $clog2(2*DIGITS) bits wide.
  - p < DIGITS: sseg=TOP; only an[DIGITS-1-p] is low.
  - p >= DIGITS: sseg=BOT; only an[p-DIGITS] is low.
- Direction on each step tick:
  - cw=1: p increments and wraps 2*DIGITS-1 -> 0.
  - cw=0: p decrements and wraps 0 -> 2*DIGITS-1.
- Step timer t (PER_W bits):
  - Counts only in RUN with en=1.
  - When t >= period, a step tick fires and t clears to 0; otherwise t increments.
  - `period` is sampled live every cycle. Lowering it below the current t causes a tick on the next counting cycle.
- Step counter sc (0..2*DIGITS-1) increments on every tick regardless of direction. It is used only for one-shot.
- States and transitions:
  - IDLE: an all 1, sseg=BLANK, busy=0.
    - start=1 -> RUN, with p=0, t=0, sc=0.
  - RUN: display is decoded from p; busy=1.
    - stop=1 -> IDLE. stop has priority over start.
    - start=1 -> restart: p=0, t=0, sc=0; stay in RUN.
    - A tick with oneshot=1 and sc=2*DIGITS-1 -> DONE; p is not advanced.
    - Any other tick: advance p and sc.
  - DONE: blank outputs, done=1, busy=0. Lasts one cycle, then -> IDLE. start in DONE is ignored.
- Input changes while running:
  - cw changing mid-run takes effect at the next tick; it does not reset sc.
  - oneshot is sampled at each tick.
  - en=0 holds t, p, sc and the display. stop and start are still honoured while en=0.
- Reset (rst=0 at an edge) forces:
  - IDLE, p=0, t=0, sc=0.
  - an all 1, sseg=BLANK, busy=0, done=0.
  - This applies from any state, including mid-run and in DONE.

## Timing
- State, p, t and sc are registered. an, sseg, busy and done are combinational decodes of those registers.
- start sampled at edge k: position 0 (an=0111 with TOP for DIGITS=4) is visible from cycle k+1.
- With en held high, each position is shown for exactly period+1 cycles.
- One-shot: with en held high, start at edge k gives done high during cycle k + 1 + 2*DIGITS*(period+1). busy is low in that same cycle.
- stop at edge k: outputs are blank from cycle k+1.
- Reset: outputs are at reset values in the cycle after the first rst=0 edge.
- No combinational path exists from any input to any output.

## Test plan
Benches use DIGITS=4 unless stated.
- Reset: hold rst=0 for 2 cycles, then release with no start -> an=4'b1111, sseg=7'b1111111, busy=0, done=0 indefinitely.
- Continuous CW (period=3, cw=1, en=1, oneshot=0, pulse start) -> in 4-cycle steps:
  - an 0111, 1011, 1101, 1110 with sseg=TOP;
  - then an 1110, 1101, 1011, 0111 with sseg=BOT;
  - then back to 0111/TOP at cycle 33.
- CCW and direction change (period=0, cw=0, start) -> 0111/BOT, 1011/BOT, ...; flip cw=1 when showing 1011/BOT -> the next cycle shows 0111/BOT.
- One-shot (period=1, oneshot=1, start) -> 8 positions of 2 cycles each, then done=1 for exactly one cycle with outputs blank, then IDLE with busy=0. A start asserted during the done cycle is ignored.
- Pause: period=3; drop en for 10 cycles while t=1 -> display frozen throughout. After en returns, the step occurs 3 cycles later.
- Priority and reset:
  - start and stop together in RUN -> blank the next cycle.
  - rst=0 mid-run (p=5) -> blank the next cycle, and a subsequent start shows position 0.
  - DIGITS=8 smoke run: CW revolution takes 16 steps, with an[7] low at p=0.
